evg_event_arbiter: RTL and testbench
====================================

Name: evg_event_arbiter

Overview:
- Schedules event codes from the sequencer, hardware-trigger and software-trigger sources, plus heartbeat requests, into the transmitter's event slots.
- Lives entirely in the evgTxClk domain, between the event sources and the transmit formatter.
- The sequencer source has no back-pressure, so it is buffered in a small FIFO. Hardware and software sources are flow-controlled with TREADY.
- Provides fixed priority with round-robin between hardware and software, plus an anti-starvation promotion.

Parameters:
- SEQ_FIFO_DEPTH, 4: sequencer buffer entries; power of 2, minimum 2.
- MAX_WAIT, 16: slots a pending hw/sw event may be passed over before it is promoted; range 1..255.
- HEARTBEAT_CODE, 8'h7A: event code emitted for a heartbeat.

Ports:
- evgTxClk  in  1  transmit clock; the only clock.
- evgTxReset  in  1  asynchronous, active-high reset.
- evgSlotAvailable  in  1  formatter can accept one event code on this cycle.
- evgSequenceEventTDATA  in  8  sequencer event code.
- evgSequenceEventTVALID  in  1  sequencer code valid; no ready, always captured.
- evgHardwareEventTDATA  in  8  hardware trigger code.
- evgHardwareEventTVALID  in  1  hardware code valid.
- evgHardwareEventTREADY  out  1  hardware code consumed this cycle.
- evgSoftwareEventTDATA  in  8  software trigger code.
- evgSoftwareEventTVALID  in  1  software code valid.
- evgSoftwareEventTREADY  out  1  software code consumed this cycle.
- evgHeartbeatRequest  in  1  single-cycle heartbeat request.
- evgOverflowClear  in  1  clears the sticky overflow flag.
- evgEventTDATA  out  8  scheduled event code to the formatter.
- evgEventTVALID  out  1  scheduled event valid; high for one cycle.
- evgSeqOverflow  out  1  sticky: a sequencer event was dropped.

Behaviour:
- Reset:
  - All outputs 0; FIFO empty; heartbeat pending cleared; round-robin pointer set to hardware; wait counter 0.
  - Reset asserted mid-operation discards all buffered and pending events immediately.
- Sequencer FIFO:
  - Each cycle with TVALID and TDATA≠0 writes one entry.
  - A TDATA=0 (null) code is ignored.
  - A write when full with a simultaneous read succeeds.
  - A write when full with no read drops the new code and sets evgSeqOverflow.
  - evgOverflowClear clears the flag. If a clear and a new overflow occur on the same cycle, the flag stays set.
- Heartbeat: a request sets the pending bit. Further requests while pending merge into it; no queueing.
- Arbitration happens only on cycles where evgSlotAvailable=1. Priority order:
  1. Promoted hw/sw request (wait counter == MAX_WAIT).
  2. FIFO head.
  3. Heartbeat.
  4. hw/sw, round-robin.
- Round-robin: after a hw or sw grant, the pointer moves to the other source. When only one source is valid, it is granted regardless of the pointer.
- TREADY:
  - Combinational: equals evgSlotAvailable AND grant-to-that-source.
  - A hw/sw code of 0 gets TREADY immediately, regardless of slot, and is discarded without consuming a slot.
- Wait counter:
  - Increments on each available slot where hw or sw is valid but neither is granted; saturates at MAX_WAIT.
  - Resets to 0 on any hw/sw grant.
  - The promoted grant goes to the source the round-robin pointer would select.
- Output:
  - Registered. evgEventTDATA/TVALID are driven the cycle after the grant; TVALID=0 when nothing is granted.
  - TDATA holds the last code while TVALID=0.
- Latency: sequencer input to output is 2 cycles minimum (FIFO write, then grant register). hw/sw TREADY to output is 1 cycle.
- Simultaneous heartbeat request and grant of the pending heartbeat: the new request re-arms the pending bit.

Optional Feature:
- Macro EVG_ARB_STATS_EN.
- When defined, adds output ports evgSeqCount, evgHwCount, evgSwCount and evgHbCount, each 32 bits.
  - Each is a wrapping count of codes emitted from that source.
  - All four are cleared by reset.
  - They are clock-domain local; the sys side reads them via the codebase's standard sync.
- When undefined, these ports and the counter logic do not exist. Arbitration behaviour is identical either way.

Decomposition:
- Package evg_pkg:
  - EVENTCODE_WIDTH=8.
  - EVENT_NULL=8'h00.
  - Default HEARTBEAT_CODE.
  - Source-select enum {SRC_NONE, SRC_SEQ, SRC_HB, SRC_HW, SRC_SW}.
- One sub-module, evg_seq_fifo: a synchronous FIFO with full, empty, and drop-on-full that raises an overflow pulse.

Test Plan:
- Reset, then slot held high; seq pushes 0x01, 0x02, 0x03 on consecutive cycles → output 0x01, 0x02, 0x03 in order, first one 2 cycles after the first push; overflow stays 0.
- Slot held low; 6 seq pushes with depth 4 → evgSeqOverflow=1. Slot then released → 0x01..0x04 emitted. evgOverflowClear → flag returns to 0.
- hw=0x10 and sw=0x20 both held valid, slot high → output alternates 0x10, 0x20, 0x10, …; each TREADY is 1 only on its grant cycle.
- Continuous seq stream with hw valid → hw granted on the 17th available slot (MAX_WAIT=16); counter resets afterwards.
- Heartbeat pulse together with hw valid, FIFO empty → 0x7A emitted first, then hw. Two heartbeat pulses while pending → a single 0x7A.
- hw TDATA=0 with slot low → TREADY=1 that cycle and no output event. Assert reset mid-stream → outputs immediately 0 and FIFO empty.

Source files
------------

// File: rtl/evg_pkg.sv
// Shared types and constants for the EVG event arbiter slice.
package evg_pkg;

    localparam int EVENTCODE_WIDTH = 8;

    typedef logic [EVENTCODE_WIDTH-1:0] evcode_t;

    localparam evcode_t EVENT_NULL             = 8'h00;
    localparam evcode_t DEFAULT_HEARTBEAT_CODE = 8'h7A;

    typedef enum logic [2:0] {
        SRC_NONE,
        SRC_SEQ,
        SRC_HB,
        SRC_HW,
        SRC_SW
    } src_e;

endpackage

// File: rtl/evg_event_arbiter_if.sv
// Event-source and formatter-side signals of the arbiter; the slave modport is the arbiter's view.
// Statistics counters exist only when EVG_ARB_STATS_EN is defined.
interface evg_event_arbiter_if;
    import evg_pkg::*;

    logic    evgSlotAvailable;
    evcode_t evgSequenceEventTDATA;
    logic    evgSequenceEventTVALID;
    evcode_t evgHardwareEventTDATA;
    logic    evgHardwareEventTVALID;
    logic    evgHardwareEventTREADY;
    evcode_t evgSoftwareEventTDATA;
    logic    evgSoftwareEventTVALID;
    logic    evgSoftwareEventTREADY;
    logic    evgHeartbeatRequest;
    logic    evgOverflowClear;
    evcode_t evgEventTDATA;
    logic    evgEventTVALID;
    logic    evgSeqOverflow;
`ifdef EVG_ARB_STATS_EN
    logic [31:0] evgSeqCount;
    logic [31:0] evgHwCount;
    logic [31:0] evgSwCount;
    logic [31:0] evgHbCount;
`endif

    modport slave (
        input  evgSlotAvailable,
        input  evgSequenceEventTDATA, evgSequenceEventTVALID,
        input  evgHardwareEventTDATA, evgHardwareEventTVALID,
        output evgHardwareEventTREADY,
        input  evgSoftwareEventTDATA, evgSoftwareEventTVALID,
        output evgSoftwareEventTREADY,
        input  evgHeartbeatRequest, evgOverflowClear,
        output evgEventTDATA, evgEventTVALID, evgSeqOverflow
`ifdef EVG_ARB_STATS_EN
        , output evgSeqCount, evgHwCount, evgSwCount, evgHbCount
`endif
    );

    modport master (
        output evgSlotAvailable,
        output evgSequenceEventTDATA, evgSequenceEventTVALID,
        output evgHardwareEventTDATA, evgHardwareEventTVALID,
        input  evgHardwareEventTREADY,
        output evgSoftwareEventTDATA, evgSoftwareEventTVALID,
        input  evgSoftwareEventTREADY,
        output evgHeartbeatRequest, evgOverflowClear,
        input  evgEventTDATA, evgEventTVALID, evgSeqOverflow
`ifdef EVG_ARB_STATS_EN
        , input evgSeqCount, evgHwCount, evgSwCount, evgHbCount
`endif
    );

endinterface

// File: rtl/evg_seq_fifo.sv
// Sequencer event buffer: synchronous FIFO that drops writes when full (unless a read frees
// a slot the same cycle) and reports each drop with a one-cycle overflow pulse.
module evg_seq_fifo
    import evg_pkg::*;
#(
    parameter int DEPTH = 4
) (
    input  logic    clk,
    input  logic    rst,
    input  logic    wr_en,
    input  evcode_t wr_data,
    input  logic    rd_en,
    output evcode_t rd_data,
    output logic    full,
    output logic    empty,
    output logic    overflow
);

    localparam int AW = $clog2(DEPTH);

    evcode_t     mem [DEPTH];
    logic [AW:0] wr_ptr;
    logic [AW:0] rd_ptr;
    logic        do_wr;
    logic        do_rd;

    // Pointers carry one wrap bit so full and empty are distinguishable.
    assign empty    = (wr_ptr == rd_ptr);
    assign full     = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
    assign do_rd    = rd_en && !empty;
    assign do_wr    = wr_en && (!full || do_rd);
    assign overflow = wr_en && full && !do_rd;
    assign rd_data  = mem[rd_ptr[AW-1:0]];

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
        end else begin
            if (do_wr) wr_ptr <= wr_ptr + (AW+1)'(1);
            if (do_rd) rd_ptr <= rd_ptr + (AW+1)'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (do_wr) mem[wr_ptr[AW-1:0]] <= wr_data;
    end

endmodule

// File: rtl/evg_event_arbiter.sv
// Schedules sequencer, heartbeat, hardware and software event codes into formatter slots.
// Optional per-source emit counters are built when EVG_ARB_STATS_EN is defined.
module evg_event_arbiter
    import evg_pkg::*;
#(
    parameter int      SEQ_FIFO_DEPTH = 4,
    parameter int      MAX_WAIT       = 16,
    parameter evcode_t HEARTBEAT_CODE = DEFAULT_HEARTBEAT_CODE
) (
    input logic                evgTxClk,
    input logic                evgTxReset,
    evg_event_arbiter_if.slave bus
);

    localparam logic [7:0] WAIT_MAX = 8'(MAX_WAIT);

    logic       slot;
    logic       hw_ok, sw_ok, hw_null, sw_null;
    logic       rr_sw;
    logic [7:0] wait_cnt;
    logic       promote;
    logic       hb_pend;
    logic       seq_wr, seq_full, seq_empty, seq_drop;
    evcode_t    seq_head;
    src_e       pick, grant;
    evcode_t    grant_code;
    evcode_t    ev_data;
    logic       ev_valid;
    logic       ovf_flag;

    assign slot    = bus.evgSlotAvailable;
    assign hw_null = bus.evgHardwareEventTVALID && (bus.evgHardwareEventTDATA == EVENT_NULL);
    assign sw_null = bus.evgSoftwareEventTVALID && (bus.evgSoftwareEventTDATA == EVENT_NULL);
    assign hw_ok   = bus.evgHardwareEventTVALID && !hw_null;
    assign sw_ok   = bus.evgSoftwareEventTVALID && !sw_null;
    assign seq_wr  = bus.evgSequenceEventTVALID && (bus.evgSequenceEventTDATA != EVENT_NULL);

    evg_seq_fifo #(.DEPTH(SEQ_FIFO_DEPTH)) u_seq_fifo (
        .clk      (evgTxClk),
        .rst      (evgTxReset),
        .wr_en    (seq_wr),
        .wr_data  (bus.evgSequenceEventTDATA),
        .rd_en    (grant == SRC_SEQ),
        .rd_data  (seq_head),
        .full     (seq_full),
        .empty    (seq_empty),
        .overflow (seq_drop)
    );

    // A lone valid source wins regardless of the pointer; the pointer only breaks ties.
    always_comb begin
        pick = SRC_NONE;
        if (hw_ok && (!sw_ok || !rr_sw)) pick = SRC_HW;
        else if (sw_ok)                  pick = SRC_SW;
    end

    assign promote = (pick != SRC_NONE) && (wait_cnt == WAIT_MAX);

    always_comb begin
        grant = SRC_NONE;
        if (slot) begin
            if (promote)         grant = pick;
            else if (!seq_empty) grant = SRC_SEQ;
            else if (hb_pend)    grant = SRC_HB;
            else                 grant = pick;
        end
    end

    always_comb begin
        grant_code = EVENT_NULL;
        case (grant)
            SRC_SEQ: grant_code = seq_head;
            SRC_HB:  grant_code = HEARTBEAT_CODE;
            SRC_HW:  grant_code = bus.evgHardwareEventTDATA;
            SRC_SW:  grant_code = bus.evgSoftwareEventTDATA;
            default: grant_code = EVENT_NULL;
        endcase
    end

    // Null hw/sw codes are flushed at once without using a slot.
    assign bus.evgHardwareEventTREADY = hw_null || (grant == SRC_HW);
    assign bus.evgSoftwareEventTREADY = sw_null || (grant == SRC_SW);

    always_ff @(posedge evgTxClk or posedge evgTxReset) begin
        if (evgTxReset) begin
            ev_data  <= EVENT_NULL;
            ev_valid <= 1'b0;
            ovf_flag <= 1'b0;
            hb_pend  <= 1'b0;
            rr_sw    <= 1'b0;
            wait_cnt <= '0;
        end else begin
            ev_valid <= (grant != SRC_NONE);
            if (grant != SRC_NONE) ev_data <= grant_code;

            if (seq_drop)                  ovf_flag <= 1'b1;
            else if (bus.evgOverflowClear) ovf_flag <= 1'b0;

            hb_pend <= bus.evgHeartbeatRequest || (hb_pend && (grant != SRC_HB));

            if (grant == SRC_HW || grant == SRC_SW) begin
                wait_cnt <= '0;
                rr_sw    <= (grant == SRC_HW);
            end else if (slot && (hw_ok || sw_ok) && wait_cnt != WAIT_MAX) begin
                wait_cnt <= wait_cnt + 8'd1;
            end
        end
    end

    assign bus.evgEventTDATA  = ev_data;
    assign bus.evgEventTVALID = ev_valid;
    assign bus.evgSeqOverflow = ovf_flag;

`ifdef EVG_ARB_STATS_EN
    logic [31:0] seq_cnt, hw_cnt, sw_cnt, hb_cnt;

    always_ff @(posedge evgTxClk or posedge evgTxReset) begin
        if (evgTxReset) begin
            seq_cnt <= '0;
            hw_cnt  <= '0;
            sw_cnt  <= '0;
            hb_cnt  <= '0;
        end else begin
            if (grant == SRC_SEQ) seq_cnt <= seq_cnt + 32'd1;
            if (grant == SRC_HW)  hw_cnt  <= hw_cnt + 32'd1;
            if (grant == SRC_SW)  sw_cnt  <= sw_cnt + 32'd1;
            if (grant == SRC_HB)  hb_cnt  <= hb_cnt + 32'd1;
        end
    end

    assign bus.evgSeqCount = seq_cnt;
    assign bus.evgHwCount  = hw_cnt;
    assign bus.evgSwCount  = sw_cnt;
    assign bus.evgHbCount  = hb_cnt;
`endif

endmodule

// File: tb/tb_evg_event_arbiter.sv
// Scoreboard bench for evg_event_arbiter: a queue-based reference model predicts each grant,
// and a negedge monitor pops and compares every emitted event code and its latency.
module tb_evg_event_arbiter;
    import evg_pkg::*;

    localparam int         DEPTH = 4;
    localparam int         MAXW  = 16;
    localparam logic [7:0] HBC   = 8'h7A;

    logic clk = 1'b0;
    logic rst = 1'b0;
    int   cyc = 0;

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    evg_event_arbiter_if ifc();

    evg_event_arbiter #(
        .SEQ_FIFO_DEPTH (DEPTH),
        .MAX_WAIT       (MAXW),
        .HEARTBEAT_CODE (HBC)
    ) dut (
        .evgTxClk   (clk),
        .evgTxReset (rst),
        .bus        (ifc.slave)
    );

    typedef struct {
        logic [7:0] code;
        int         cyc;
    } exp_t;

    exp_t       sb[$];
    logic [7:0] exp_last = 8'h00;
    int         n_vec = 0;
    int         n_err = 0;

    // Reference model state
    logic [7:0] mq[$];
    bit         m_hb, m_rr_sw, m_ovf;
    int         m_wait;

    // Source state: mode 0 drops valid after consumption, 1 re-offers the same code
    bit         hw_v, sw_v;
    logic [7:0] hw_d, sw_d;
    int         hw_mode, sw_mode;
    bit         dut_hw_rdy;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    task automatic model_clear();
        mq.delete();
        sb.delete();
        m_hb = 0; m_rr_sw = 0; m_ovf = 0; m_wait = 0;
        hw_v = 0; sw_v = 0; hw_d = 0; sw_d = 0; hw_mode = 0; sw_mode = 0;
        exp_last = 8'h00;
    endtask

    task automatic drive_idle();
        ifc.evgSlotAvailable       = 0;
        ifc.evgSequenceEventTDATA  = 0;
        ifc.evgSequenceEventTVALID = 0;
        ifc.evgHardwareEventTDATA  = 0;
        ifc.evgHardwareEventTVALID = 0;
        ifc.evgSoftwareEventTDATA  = 0;
        ifc.evgSoftwareEventTVALID = 0;
        ifc.evgHeartbeatRequest    = 0;
        ifc.evgOverflowClear       = 0;
    endtask

    // One clock of stimulus plus the model's prediction for that cycle.
    task automatic step(input bit slot, input bit sv, input logic [7:0] sd, input bit hb, input bit clr);
        src_e       g, pick;
        logic [7:0] code;
        bit         hw_ok, sw_ok, hw_rdy, sw_rdy, drop;
        @(posedge clk);
        #1;
        check("seq_overflow", ifc.evgSeqOverflow, m_ovf);
        ifc.evgSlotAvailable       = slot;
        ifc.evgSequenceEventTVALID = sv;
        ifc.evgSequenceEventTDATA  = sd;
        ifc.evgHardwareEventTVALID = hw_v;
        ifc.evgHardwareEventTDATA  = hw_d;
        ifc.evgSoftwareEventTVALID = sw_v;
        ifc.evgSoftwareEventTDATA  = sw_d;
        ifc.evgHeartbeatRequest    = hb;
        ifc.evgOverflowClear       = clr;
        #1;
        hw_ok = hw_v && hw_d != 8'h00;
        sw_ok = sw_v && sw_d != 8'h00;
        pick  = SRC_NONE;
        g     = SRC_NONE;
        if (hw_ok && sw_ok) pick = m_rr_sw ? SRC_SW : SRC_HW;
        else if (hw_ok)     pick = SRC_HW;
        else if (sw_ok)     pick = SRC_SW;
        if (slot) begin
            if (pick != SRC_NONE && m_wait >= MAXW) g = pick;
            else if (mq.size() > 0)                 g = SRC_SEQ;
            else if (m_hb)                          g = SRC_HB;
            else                                    g = pick;
        end
        hw_rdy = (hw_v && hw_d == 8'h00) || g == SRC_HW;
        sw_rdy = (sw_v && sw_d == 8'h00) || g == SRC_SW;
        dut_hw_rdy = ifc.evgHardwareEventTREADY;
        check("hw_tready", ifc.evgHardwareEventTREADY, hw_rdy);
        check("sw_tready", ifc.evgSoftwareEventTREADY, sw_rdy);

        code = 8'h00;
        case (g)
            SRC_SEQ: code = mq[0];
            SRC_HB:  code = HBC;
            SRC_HW:  code = hw_d;
            SRC_SW:  code = sw_d;
            default: code = 8'h00;
        endcase
        if (g != SRC_NONE) sb.push_back('{code: code, cyc: cyc});

        if (g == SRC_SEQ) void'(mq.pop_front());
        drop = 0;
        if (sv && sd != 8'h00) begin
            if (mq.size() < DEPTH) mq.push_back(sd);
            else                   drop = 1;
        end
        if (drop)     m_ovf = 1;
        else if (clr) m_ovf = 0;
        m_hb = hb || (m_hb && g != SRC_HB);
        if (g == SRC_HW || g == SRC_SW) begin
            m_wait  = 0;
            m_rr_sw = (g == SRC_HW);
        end else if (slot && (hw_ok || sw_ok) && m_wait < MAXW) begin
            m_wait++;
        end

        if (hw_rdy && hw_mode == 0) hw_v = 0;
        if (sw_rdy && sw_mode == 0) sw_v = 0;
    endtask

    task automatic idle(input int n, input bit slot);
        repeat (n) step(slot, 0, 8'h00, 0, 0);
    endtask

    // Asynchronous reset applied mid-cycle: outputs must clear without waiting for an edge.
    task automatic do_reset();
        rst = 1;
        model_clear();
        drive_idle();
        #1;
        check("rst_tvalid", ifc.evgEventTVALID, 0);
        check("rst_tdata", ifc.evgEventTDATA, 0);
        check("rst_overflow", ifc.evgSeqOverflow, 0);
        repeat (2) @(posedge clk);
        #2 rst = 0;
    endtask

    task automatic rand_phase(input int n, input int seq_pct);
        for (int i = 0; i < n; i++) begin
            if (!hw_v && $urandom_range(3) == 0) begin
                hw_v = 1;
                hw_d = ($urandom_range(7) == 0) ? 8'h00 : 8'($urandom_range(255));
            end
            if (!sw_v && $urandom_range(3) == 0) begin
                sw_v = 1;
                sw_d = ($urandom_range(7) == 0) ? 8'h00 : 8'($urandom_range(255));
            end
            step($urandom_range(3) != 0, $urandom_range(99) < seq_pct, 8'($urandom_range(255)),
                 $urandom_range(15) == 0, $urandom_range(31) == 0);
        end
    endtask

    // Monitor: every emitted event must match the oldest prediction, one cycle after its grant.
    initial begin
        exp_t e;
        forever begin
            @(negedge clk);
            if (ifc.evgEventTVALID === 1'b1) begin
                if (sb.size() == 0) begin
                    n_vec++;
                    n_err++;
                    $display("FAIL unexpected_event: got %0h expected none (cycle %0d)", ifc.evgEventTDATA, cyc);
                end else begin
                    e = sb.pop_front();
                    check("event_code", ifc.evgEventTDATA, e.code);
                    check("event_latency", cyc, e.cyc + 1);
                    exp_last = e.code;
                end
            end else begin
                check("tdata_hold", ifc.evgEventTDATA, exp_last);
            end
        end
    end

    initial begin
        int slots;
        bit got;
        model_clear();
        drive_idle();
        #1 rst = 1;
        #1;
        check("rst_tvalid", ifc.evgEventTVALID, 0);
        check("rst_tdata", ifc.evgEventTDATA, 0);
        check("rst_overflow", ifc.evgSeqOverflow, 0);
        repeat (2) @(posedge clk);
        #2 rst = 0;

        // In-order sequencer pass-through
        step(1, 1, 8'h01, 0, 0);
        step(1, 1, 8'h02, 0, 0);
        step(1, 1, 8'h03, 0, 0);
        idle(4, 1);

        // Overflow with slot held off, then drain and clear
        for (int i = 1; i <= 6; i++) step(0, 1, 8'(i), 0, 0);
        idle(6, 1);
        step(0, 0, 8'h00, 0, 1);
        idle(2, 0);

        // hw/sw round-robin
        hw_v = 1; hw_d = 8'h10; hw_mode = 1;
        sw_v = 1; sw_d = 8'h20; sw_mode = 1;
        idle(8, 1);
        hw_mode = 0; sw_mode = 0;
        idle(4, 1);

        // Starvation promotion under a continuous sequencer stream
        step(0, 1, 8'h30, 0, 0);
        step(0, 1, 8'h31, 0, 0);
        hw_v = 1; hw_d = 8'h44;
        slots = 0;
        got = 0;
        for (int i = 0; i < 40 && !got; i++) begin
            step(1, 1, 8'(8'h50 + i), 0, 0);
            slots++;
            if (dut_hw_rdy) got = 1;
        end
        check("promote_slot", got ? slots : 0, 17);
        hw_v = 0;
        idle(8, 1);

        // Heartbeat ahead of hw; merged heartbeat requests
        hw_v = 1; hw_d = 8'h55;
        step(0, 0, 8'h00, 1, 0);
        idle(3, 1);
        step(0, 0, 8'h00, 1, 0);
        step(0, 0, 8'h00, 1, 0);
        idle(3, 1);

        // Null hw code flushed with no slot
        hw_v = 1; hw_d = 8'h00;
        idle(2, 0);

        // Randomized traffic with a reset in the middle of a busy stream
        rand_phase(1500, 70);
        do_reset();
        idle(3, 1);
        rand_phase(1500, 25);

        hw_v = 0; sw_v = 0;
        idle(4, 0);
        check("sb_drained", sb.size(), 0);
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
